// File: rtl/pair_serializer.sv
// pair_serializer: emits a captured {d0,d1} pair as two sequential words with valid/ready on both sides
module pair_serializer #(
  parameter int WIDTH    = 8,
  parameter bit FIRST_D1 = 1'b0,
  parameter int CNTW     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d0,
  input  logic [WIDTH-1:0] in_d1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNTW-1:0]  pair_cnt
);
  typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] h0_q, h1_q;
  logic [CNTW-1:0] cnt_q;
  logic in_acc, out_acc;
  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  // a new pair can land in the same edge that retires the second word
  always_comb begin
    state_d = state_q == IDLE  ? (in_acc ? SEND0 : IDLE) :
              state_q == SEND0 ? (out_acc ? SEND1 : SEND0) :
              out_acc          ? (in_acc ? SEND0 : IDLE) : SEND1;
  end
  always_comb begin
    out_valid = state_q != IDLE;
    out_last  = state_q == SEND1;
    in_ready  = state_q == IDLE || (state_q == SEND1 && out_ready);
    out_data  = state_q == SEND1 ? h1_q : h0_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h0_q  <= '0;
      h1_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (in_acc) begin
        h0_q <= FIRST_D1 ? in_d1 : in_d0;
        h1_q <= FIRST_D1 ? in_d0 : in_d1;
      end
      if (out_acc && state_q == SEND1) cnt_q <= cnt_q + 1'b1;
    end
  end
  assign pair_cnt = cnt_q;
endmodule

// File: tb/tb_pair_serializer.sv
// tb_pair_serializer: vector table, directed corner sequences and random traffic against a word-queue model
module tb_pair_serializer;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_d0 = '0, in_d1 = '0;
  logic rdy0, rdy1, rdy2, v0, v1, v2, l0, l1, l2;
  logic [7:0] d0o, d1o, d2o, c0, c1;
  logic [1:0] c2;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pair_serializer #(.WIDTH(8), .FIRST_D1(1'b0), .CNTW(8)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_d0(in_d0), .in_d1(in_d1),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0o), .out_last(l0), .pair_cnt(c0));
  pair_serializer #(.WIDTH(8), .FIRST_D1(1'b1), .CNTW(8)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_d0(in_d0), .in_d1(in_d1),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1o), .out_last(l1), .pair_cnt(c1));
  pair_serializer #(.WIDTH(8), .FIRST_D1(1'b0), .CNTW(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_d0(in_d0), .in_d1(in_d1),
    .out_valid(v2), .out_ready(out_ready), .out_data(d2o), .out_last(l2), .pair_cnt(c2));

  // model: words still owed to the consumer, in emission order
  logic [7:0] q0[$], q1[$];
  logic [7:0] idle0 = '0, idle1 = '0;
  int pairs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return q0.size() == 0 || (q0.size() == 1 && out_ready);
  endfunction

  task automatic model_check();
    bit mv = q0.size() != 0;
    chk("valid0", v0, mv); chk("valid1", v1, mv); chk("valid2", v2, mv);
    chk("last0", l0, q0.size() == 1); chk("last1", l1, q1.size() == 1); chk("last2", l2, q0.size() == 1);
    chk("ready0", rdy0, m_ready()); chk("ready1", rdy1, m_ready()); chk("ready2", rdy2, m_ready());
    chk("data0", d0o, mv ? q0[0] : idle0);
    chk("data1", d1o, mv ? q1[0] : idle1);
    chk("data2", d2o, mv ? q0[0] : idle0);
    chk("cnt0", c0, pairs % 256); chk("cnt1", c1, pairs % 256); chk("cnt2", c2, pairs % 4);
  endtask

  task automatic step(input bit iv, input bit ordy, input logic [7:0] a, input logic [7:0] b);
    bit ai, ao;
    in_valid = iv; out_ready = ordy; in_d0 = a; in_d1 = b;
    #1;
    model_check();
    ai = iv && m_ready();
    ao = q0.size() != 0 && ordy;
    @(posedge clk);
    if (ao) begin
      if (q0.size() == 1) pairs++;
      void'(q0.pop_front()); void'(q1.pop_front());
    end
    if (ai) begin
      q0.push_back(a); q0.push_back(b);
      q1.push_back(b); q1.push_back(a);
      idle0 = a; idle1 = b;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", v0, 0); chk("rst_last", l0, 0); chk("rst_data", d0o, 0);
    chk("rst_cnt", c0, 0); chk("rst_ready", rdy0, 1);
    chk("rst_valid2", v2, 0); chk("rst_cnt2", c2, 0);
    q0.delete(); q1.delete(); idle0 = '0; idle1 = '0; pairs = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit iv, ordy; logic [7:0] a, b;
    bit ev, el, er; logic [7:0] ed, ec;
  } vec_t;

  initial begin
    vec_t tbl[11];
    logic [7:0] wrap_exp[5];
    tbl[0]  = '{1, 1, 8'h11, 8'h22, 0, 0, 1, 8'h00, 0};
    tbl[1]  = '{0, 1, 8'h00, 8'h00, 1, 0, 0, 8'h11, 0};
    tbl[2]  = '{0, 1, 8'h00, 8'h00, 1, 1, 1, 8'h22, 0};
    tbl[3]  = '{1, 1, 8'hA0, 8'hA1, 0, 0, 1, 8'h11, 1};
    tbl[4]  = '{1, 1, 8'hB0, 8'hB1, 1, 0, 0, 8'hA0, 1};
    tbl[5]  = '{1, 1, 8'hB0, 8'hB1, 1, 1, 1, 8'hA1, 1};
    tbl[6]  = '{1, 1, 8'hC0, 8'hC1, 1, 0, 0, 8'hB0, 2};
    tbl[7]  = '{1, 1, 8'hC0, 8'hC1, 1, 1, 1, 8'hB1, 2};
    tbl[8]  = '{0, 1, 8'h00, 8'h00, 1, 0, 0, 8'hC0, 3};
    tbl[9]  = '{0, 1, 8'h00, 8'h00, 1, 1, 1, 8'hC1, 3};
    tbl[10] = '{0, 1, 8'h00, 8'h00, 0, 0, 1, 8'hC0, 4};
    wrap_exp = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 11; i++) begin
      in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
      #1;
      chk("tbl_valid", v0, tbl[i].ev); chk("tbl_last", l0, tbl[i].el);
      chk("tbl_ready", rdy0, tbl[i].er); chk("tbl_data", d0o, tbl[i].ed);
      chk("tbl_cnt", c0, tbl[i].ec);
      #0 step(tbl[i].iv, tbl[i].ordy, tbl[i].a, tbl[i].b);
    end
    step(1, 1, 8'h5A, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'hFF, 8'hFF);
      chk("bp_s0_data", d0o, 8'h5A); chk("bp_s0_last", l0, 0); chk("bp_s0_ready", rdy0, 0);
      chk("bp_s0_data1", d1o, 8'hA5);
    end
    step(0, 1, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 8'hEE, 8'hEE);
      chk("bp_s1_data", d0o, 8'hA5); chk("bp_s1_last", l0, 1); chk("bp_s1_ready", rdy0, 0);
    end
    step(0, 1, 8'h00, 8'h00);
    step(0, 1, 8'h00, 8'h00);
    step(1, 1, 8'h01, 8'h02);
    chk("fd1_first", d1o, 8'h02); chk("fd1_first_last", l1, 0);
    step(0, 1, 8'h00, 8'h00);
    chk("fd1_second", d1o, 8'h01); chk("fd1_second_last", l1, 1);
    step(0, 1, 8'h00, 8'h00);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 8'(k * 2), 8'(k * 2 + 1));
      step(0, 1, 8'h00, 8'h00);
      step(0, 1, 8'h00, 8'h00);
      chk("wrap_cnt", c2, wrap_exp[k][1:0]);
    end
    step(1, 1, 8'h33, 8'h44);
    step(0, 1, 8'h00, 8'h00);
    chk("mid_in_send1", l0, 1);
    #2;
    do_reset();
    step(1, 1, 8'h55, 8'h66);
    step(0, 1, 8'h00, 8'h00);
    step(0, 1, 8'h00, 8'h00);
    step(0, 1, 8'h00, 8'h00);
    chk("post_rst_cnt", c2, 1);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
